decoder_n_scan: RTL

Parametrised, registered N-to-2^N one-hot decoder with enable, a valid/ready load handshake and an auto-scan mode. In scan mode it walks the active output through every code at a programmable dwell rate. It is the general successor of the fixed 2-to-4 decoder and drives select/strobe lines (display digit enables, bank selects) whose active line must be held or rotated without per-cycle software control.

---
 rtl/decoder_n_scan_pkg.sv | 14 +
 rtl/decoder_n_scan_if.sv | 26 ++
 rtl/decoder_n_scan_onehot_dec.sv | 16 +
 rtl/decoder_n_scan.sv | 108 ++++++++++
 4 files changed

// File: rtl/decoder_n_scan_pkg.sv
// Shared types for the one-hot select decoder: FSM state encoding and mode values.
// Imported by the top and sub-module; holds no logic.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_n_scan_if.sv
// Load handshake plus decoded select outputs; master drives code/control, slave owns outputs.
// in_ready is combinational from the slave; everything else on the slave side is registered.
interface decoder_n_scan_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 2**SEL_W;

    logic               en;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in;
    logic [0:OUT_W-1]   y;
    logic [SEL_W-1:0]   cur;
    logic               wrap;

    modport master (
        output en, mode, in_valid, in,
        input  in_ready, y, cur, wrap
    );

    modport slave (
        input  en, mode, in_valid, in,
        output in_ready, y, cur, wrap
    );
endinterface

// File: rtl/decoder_n_scan_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable; zero latency.
// No handshake; all zeros when disabled.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                  i_en,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [0:(2**SEL_W)-1] o_dec
);
    always_comb begin
        o_dec = '0;
        if (i_en) begin
            o_dec[i_sel] = 1'b1;
        end
    end
endmodule

// File: rtl/decoder_n_scan.sv
// Registered one-hot select driver with hold and auto-scan; load visible one cycle after accept.
// Loads are refused (in_ready low) while scanning or disabled.
module decoder_n_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_n_scan_if.slave  bus
);
    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [0:OUT_W-1] Y_IDLE  = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_cur;
    logic [SEL_W-1:0]   w_cur_nxt;
    logic [SEL_W-1:0]   w_cur_inc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic [0:OUT_W-1]   r_y;
    logic [0:OUT_W-1]   w_dec;
    logic               w_load;

    assign bus.in_ready = bus.en && (r_state != SCAN);
    assign w_load       = bus.in_valid && bus.in_ready;
    assign w_cur_inc    = r_cur + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_cur_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_load) begin
                        w_cur_nxt   = bus.in;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (bus.mode == MODE_SCAN) ? SCAN : HOLD;
                    end else if (r_state == HOLD && bus.mode == MODE_SCAN) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = SCAN;
                    end
                end
                SCAN: begin
                    // Leaving scan freezes the visible code; no increment on that edge.
                    if (bus.mode == MODE_DECODE) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_MAX) begin
                        w_cnt_nxt  = '0;
                        w_cur_nxt  = w_cur_inc;
                        w_wrap_nxt = (w_cur_inc == '0);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cur_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Decode the next-cycle code so y lines up with cur from the same edge.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .i_en  (w_state_nxt != IDLE),
        .i_sel (w_cur_nxt),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_y     <= Y_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
            r_y     <= (ACTIVE_LOW != 0) ? ~w_dec : w_dec;
        end
    end

    assign bus.y    = r_y;
    assign bus.cur  = r_cur;
    assign bus.wrap = r_wrap;

endmodule
